// File: rtl/fft8_pkg.sv
// Shared constants, FSM state type and slot-order helper for the FFT8 sample loader.
package fft8_pkg;

    localparam int unsigned N_POINTS       = 8;
    localparam int unsigned IDX_W          = 3;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT
    } state_t;

    // Reverse the three index bits: sample n lands in slot bitrev3(n).
    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft8_sample_loader_if.sv
// Sample stream into the loader: valid/ready handshake carrying one complex sample.
interface fft8_sample_loader_if
    import fft8_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/fft8_sample_loader.sv
// Collects eight streamed samples into a frame, strobes the FFT core, and waits
// for its completion flag (or a timeout) before accepting the next frame.
module fft8_sample_loader
    import fft8_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned PULSE_CYCLES = 5,
    parameter int unsigned TIMEOUT      = 255,
    parameter bit          BITREV       = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    fft8_sample_loader_if.slave in_if,
    output logic [DATA_W-1:0]   x0,
    output logic [DATA_W-1:0]   x1,
    output logic [DATA_W-1:0]   x2,
    output logic [DATA_W-1:0]   x3,
    output logic [DATA_W-1:0]   x4,
    output logic [DATA_W-1:0]   x5,
    output logic [DATA_W-1:0]   x6,
    output logic [DATA_W-1:0]   x7,
    output logic                input_pulse,
    input  logic                success,
    output logic                frame_done,
    output logic                err_timeout,
    output logic [7:0]          frame_cnt
);

    // One counter serves both the pulse phase and the wait phase.
    localparam int unsigned CNT_MAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic [DATA_W-1:0]  slot_q [N_POINTS];

    logic               wr_en;
    logic [IDX_W-1:0]   wr_slot;

    // Next-state, slot-write and counter decisions for the FILL/LAUNCH/WAIT cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        wr_en   = 1'b0;
        wr_slot = BITREV ? bitrev3(idx_q) : idx_q;

        case (state_q)
            FILL: begin
                if (in_if.in_valid) begin
                    wr_en = 1'b1;
                    if (idx_q == IDX_W'(N_POINTS - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = LAUNCH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LAUNCH: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                // Success takes priority over a timeout landing in the same cycle.
                if (success) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 8'd1;
                    state_d = FILL;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control state registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Frame register bank; only FILL-state accepts write it, so it holds through LAUNCH/WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_POINTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en) begin
            slot_q[wr_slot] <= in_if.in_data;
        end
    end

    // Strobe decoded from the state register so reset drops it immediately.
    assign input_pulse    = (state_q == LAUNCH);
    assign in_if.in_ready = (state_q == FILL);
    assign frame_done     = done_q;
    assign err_timeout    = err_q;
    assign frame_cnt      = fcnt_q;

    assign x0 = slot_q[0];
    assign x1 = slot_q[1];
    assign x2 = slot_q[2];
    assign x3 = slot_q[3];
    assign x4 = slot_q[4];
    assign x5 = slot_q[5];
    assign x6 = slot_q[6];
    assign x7 = slot_q[7];

endmodule

// File: tb/tb_fft8_sample_loader.sv
// Scoreboard bench: one bit-reversed and one natural-order loader driven by the same stream.
`timescale 1ns/1ps
module tb_fft8_sample_loader;
    import fft8_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned PULSE = 5;
    localparam int unsigned TMO   = 255;
    localparam int          BOUND = 400;

    typedef logic [7:0][DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          success = 1'b0;
    logic [DW-1:0] drv_data = '0;
    logic          drv_valid = 1'b0;
    int unsigned   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft8_sample_loader_if #(.DATA_W(DW)) if_br ();
    fft8_sample_loader_if #(.DATA_W(DW)) if_nat ();
    assign if_br.in_data   = drv_data;
    assign if_br.in_valid  = drv_valid;
    assign if_nat.in_data  = drv_data;
    assign if_nat.in_valid = drv_valid;

    logic [DW-1:0] xo [2][8];
    logic          pulse [2];
    logic          done [2];
    logic          err [2];
    logic [7:0]    fcnt [2];
    logic          rdy [2];
    assign rdy[0] = if_br.in_ready;
    assign rdy[1] = if_nat.in_ready;

    fft8_sample_loader #(.DATA_W(DW), .PULSE_CYCLES(PULSE), .TIMEOUT(TMO), .BITREV(1'b1)) dut_br (
        .clk(clk), .reset_n(reset_n), .in_if(if_br),
        .x0(xo[0][0]), .x1(xo[0][1]), .x2(xo[0][2]), .x3(xo[0][3]),
        .x4(xo[0][4]), .x5(xo[0][5]), .x6(xo[0][6]), .x7(xo[0][7]),
        .input_pulse(pulse[0]), .success(success), .frame_done(done[0]),
        .err_timeout(err[0]), .frame_cnt(fcnt[0])
    );

    fft8_sample_loader #(.DATA_W(DW), .PULSE_CYCLES(PULSE), .TIMEOUT(TMO), .BITREV(1'b0)) dut_nat (
        .clk(clk), .reset_n(reset_n), .in_if(if_nat),
        .x0(xo[1][0]), .x1(xo[1][1]), .x2(xo[1][2]), .x3(xo[1][3]),
        .x4(xo[1][4]), .x5(xo[1][5]), .x6(xo[1][6]), .x7(xo[1][7]),
        .input_pulse(pulse[1]), .success(success), .frame_done(done[1]),
        .err_timeout(err[1]), .frame_cnt(fcnt[1])
    );

    // Hand-derived slot k <- sample number for 3-bit bit reversal.
    int unsigned br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    int checks = 0;
    int passes = 0;

    frame_t     exp_fq0 [$];
    frame_t     exp_fq1 [$];
    logic [7:0] exp_cq0 [$];
    logic [7:0] exp_cq1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_frame(input string name, input frame_t act, input frame_t exp);
        int bad = -1;
        checks++;
        for (int k = 7; k >= 0; k--) if (act[k] !== exp[k]) bad = k;
        if (bad < 0) passes++;
        else $display("FAIL %s: slot %0d got 0x%0h expected 0x%0h", name, bad, act[bad], exp[bad]);
    endtask

    task automatic fail_event(input string name);
        checks++;
        $display("FAIL %s: event seen with got 1 expected 0 pending entries", name);
    endtask

    task automatic abort(input string name);
        checks++;
        $display("FAIL %s: got timeout expected event within %0d cycles", name, BOUND);
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "bench stopped");
    endtask

    function automatic int fq_size(input int d);
        return (d == 0) ? exp_fq0.size() : exp_fq1.size();
    endfunction
    function automatic frame_t fq_pop(input int d);
        if (d == 0) return exp_fq0.pop_front();
        return exp_fq1.pop_front();
    endfunction
    function automatic int cq_size(input int d);
        return (d == 0) ? exp_cq0.size() : exp_cq1.size();
    endfunction
    function automatic logic [7:0] cq_pop(input int d);
        if (d == 0) return exp_cq0.pop_front();
        return exp_cq1.pop_front();
    endfunction

    // Monitor: compares frames on launch, pulse length and stability, and frame_cnt on frame_done.
    frame_t      snap [2];
    int unsigned plen [2] = '{0, 0};
    logic        pulse_prev [2] = '{1'b0, 1'b0};
    logic        done_prev [2] = '{1'b0, 1'b0};
    int unsigned done_cnt [2] = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                frame_t cur;
                for (int k = 0; k < 8; k++) cur[k] = xo[d][k];
                if (!reset_n) begin
                    pulse_prev[d] = 1'b0;
                    done_prev[d]  = 1'b0;
                    plen[d]       = 0;
                end else begin
                    if (pulse[d] && !pulse_prev[d]) begin
                        snap[d] = cur;
                        plen[d] = 1;
                        if (fq_size(d) == 0) fail_event($sformatf("unexpected launch[%0d]", d));
                        else check_frame($sformatf("frame contents[%0d]", d), cur, fq_pop(d));
                    end else if (pulse[d]) begin
                        plen[d]++;
                    end else if (pulse_prev[d]) begin
                        check($sformatf("pulse length[%0d]", d), plen[d], PULSE);
                        check_frame($sformatf("launch stability[%0d]", d), cur, snap[d]);
                    end
                    if (done[d]) begin
                        check($sformatf("frame_done width[%0d]", d), 32'(done_prev[d]), 32'd0);
                        if (cq_size(d) == 0) fail_event($sformatf("unexpected frame_done[%0d]", d));
                        else check($sformatf("frame_cnt[%0d]", d), 32'(fcnt[d]), 32'(cq_pop(d)));
                        check_frame($sformatf("wait stability[%0d]", d), cur, snap[d]);
                        done_cnt[d]++;
                    end
                    pulse_prev[d] = pulse[d];
                    done_prev[d]  = done[d];
                end
            end
        end
    end

    task automatic push_cnt(input logic [7:0] c);
        exp_cq0.push_back(c);
        exp_cq1.push_back(c);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_sample(input logic [DW-1:0] v, output int unsigned acc_cyc);
        int g = 0;
        drv_data  = v;
        drv_valid = 1'b1;
        while (!rdy[0] && g < BOUND) begin
            @(negedge clk);
            g++;
        end
        if (!rdy[0]) abort("accept wait");
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic send_frame(input frame_t data, input bit keep_valid, output int unsigned first_cyc);
        frame_t      e_br, e_nat;
        int unsigned t;
        for (int k = 0; k < 8; k++) begin
            e_nat[k] = data[k];
            e_br[k]  = data[br_tab[k]];
        end
        exp_fq0.push_back(e_br);
        exp_fq1.push_back(e_nat);
        first_cyc = 0;
        for (int n = 0; n < 8; n++) begin
            send_sample(data[n], t);
            if (n == 0) first_cyc = t;
        end
        if (!keep_valid) drv_valid = 1'b0;
    endtask

    task automatic wait_pulse_low();
        int g = 0;
        while (pulse[0] && g < BOUND) begin
            @(negedge clk);
            g++;
        end
        if (pulse[0]) abort("pulse fall");
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done[0] && g < BOUND) begin
            @(negedge clk);
            g++;
        end
        if (!done[0]) abort("frame_done wait");
    endtask

    initial begin
        #500000;
        abort("global watchdog");
    end

    initial begin
        frame_t      f;
        int unsigned t, t0, t255, wcnt;
        int unsigned base_done [2];
        bit          saw_ready;

        // Reset values
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset in_ready[%0d]", d), 32'(rdy[d]), 32'd1);
            check($sformatf("reset input_pulse[%0d]", d), 32'(pulse[d]), 32'd0);
            check($sformatf("reset frame_done[%0d]", d), 32'(done[d]), 32'd0);
            check($sformatf("reset err_timeout[%0d]", d), 32'(err[d]), 32'd0);
            check($sformatf("reset frame_cnt[%0d]", d), 32'(fcnt[d]), 32'd0);
            for (int k = 0; k < 8; k++) check($sformatf("reset x%0d[%0d]", k, d), xo[d][k], 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Frame A: samples 0..7, success 3 cycles after the pulse ends
        for (int n = 0; n < 8; n++) f[n] = 32'(n);
        push_cnt(8'd1);
        send_frame(f, 1'b0, t);
        check("pulse latency br", 32'(pulse[0]), 32'd1);
        check("pulse latency nat", 32'(pulse[1]), 32'd1);
        check("ready low in launch", 32'(rdy[0]), 32'd0);
        wait_pulse_low();
        repeat (3) @(negedge clk);
        check("no early frame_done", 32'(done[0]), 32'd0);
        success = 1'b1;
        @(negedge clk);
        success = 1'b0;
        check("ready after done br", 32'(rdy[0]), 32'd1);
        check("ready after done nat", 32'(rdy[1]), 32'd1);

        // Frame B with the next sample held on the bus through LAUNCH/WAIT
        for (int n = 0; n < 8; n++) f[n] = 32'h100 + 32'(n);
        push_cnt(8'd2);
        send_frame(f, 1'b1, t);
        drv_data  = 32'h2000;
        saw_ready = 1'b0;
        repeat (15) begin
            if (rdy[0] || rdy[1]) saw_ready = 1'b1;
            @(negedge clk);
        end
        check("ready held low", 32'(saw_ready), 32'd0);
        success = 1'b1;
        @(negedge clk);
        success = 1'b0;

        // Frame C starts with the held sample and is never acknowledged
        for (int n = 0; n < 8; n++) f[n] = 32'h2000 + 32'(n);
        send_frame(f, 1'b0, t);
        wait_pulse_low();
        check("err before timeout", 32'(err[0]), 32'd0);
        wcnt = 0;
        while (!rdy[0] && wcnt < BOUND) begin
            wcnt++;
            @(negedge clk);
        end
        check("wait cycles before timeout", wcnt, TMO);
        check("err_timeout br", 32'(err[0]), 32'd1);
        check("err_timeout nat", 32'(err[1]), 32'd1);
        check("frame_cnt after timeout", 32'(fcnt[0]), 32'd2);

        // Frame D completes normally; error stays set
        for (int n = 0; n < 8; n++) f[n] = 32'h300 + 32'(n);
        push_cnt(8'd3);
        success = 1'b1;
        send_frame(f, 1'b0, t);
        wait_done();
        success = 1'b0;
        @(negedge clk);
        check("err sticky", 32'(err[0]), 32'd1);

        // Reset after four accepts
        for (int n = 0; n < 4; n++) send_sample(32'h400 + 32'(n), t);
        drv_valid = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) check($sformatf("partial reset x%0d", k), xo[0][k], 32'd0);
        check("partial reset ready", 32'(rdy[0]), 32'd1);
        check("partial reset err", 32'(err[0]), 32'd0);
        check("partial reset frame_cnt", 32'(fcnt[0]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of LAUNCH
        for (int n = 0; n < 8; n++) f[n] = 32'h500 + 32'(n);
        send_frame(f, 1'b0, t);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async pulse drop br", 32'(pulse[0]), 32'd0);
        check("async pulse drop nat", 32'(pulse[1]), 32'd0);
        check("async reset x0", xo[0][0], 32'd0);
        check("async reset ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // First frame after reset must start at slot 0
        for (int n = 0; n < 8; n++) f[n] = 32'h600 + 32'(n);
        push_cnt(8'd1);
        success = 1'b1;
        send_frame(f, 1'b0, t);
        wait_done();
        success = 1'b0;

        // 256 back-to-back frames with success tied high
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base_done[0] = done_cnt[0];
        base_done[1] = done_cnt[1];
        success = 1'b1;
        t0 = 0;
        t255 = 0;
        for (int i = 0; i < 256; i++) begin
            for (int n = 0; n < 8; n++) f[n] = (32'(i) << 8) | 32'(n);
            push_cnt(8'((i + 1) % 256));
            send_frame(f, 1'b1, t);
            if (i == 0) t0 = t;
            if (i == 255) t255 = t;
        end
        drv_valid = 1'b0;
        wait_done();
        success = 1'b0;
        @(negedge clk);
        check("frame_cnt wrap br", 32'(fcnt[0]), 32'd0);
        check("frame_cnt wrap nat", 32'(fcnt[1]), 32'd0);
        check("frame_done count br", done_cnt[0] - base_done[0], 32'd256);
        check("frame_done count nat", done_cnt[1] - base_done[1], 32'd256);
        check("min frame period", t255 - t0, 32'(255 * (8 + PULSE + 1)));

        // Every queued expectation must have been consumed
        check("frame queue br empty", 32'(exp_fq0.size()), 32'd0);
        check("frame queue nat empty", 32'(exp_fq1.size()), 32'd0);
        check("count queue br empty", 32'(exp_cq0.size()), 32'd0);
        check("count queue nat empty", 32'(exp_cq1.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
